// File: rtl/vproc_mem_pkg.sv
// Shared constants for the VProc memory slave: FSM state encodings and latency limits.
package vproc_mem_pkg;

   localparam int unsigned MAX_LATENCY = 15;
   localparam int unsigned CNT_W       = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   // Counter preload for a given latency (counter runs latency-1 .. 1 in BUSY)
   function automatic logic [CNT_W-1:0] lat_preload(input int unsigned lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/vproc_mem_array.sv
// Byte-enabled single-port storage with registered read.
module vproc_mem_array #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_BITS  = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                      clk,
  input  logic                      wr,
  input  logic                      rd,
  input  logic [ADDR_BITS-1:0]      addr,
  input  logic [DATA_WIDTH/8-1:0]   be,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // Byte-lane writes; lanes with a clear enable keep their old contents
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Registered read port; holds its value between reads
  always_ff @(posedge clk) begin
    if (rd) rdata <= mem[addr];
  end

endmodule

// File: rtl/vproc_mem.sv
// Latency-configurable memory slave for a VProc node: address decode, op FSM,
// latency counter and registered one-cycle acknowledges.
module vproc_mem
   import vproc_mem_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_BITS  = 10,
   parameter logic [31:0] SEL_MASK   = 32'hf000_0000,
   parameter logic [31:0] SEL_BASE   = 32'ha000_0000,
   parameter int          RD_LATENCY = 1,
   parameter int          WR_LATENCY = 1,
   parameter string       INIT_FILE  = ""
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             Addr,
   input  logic                    WE,
   input  logic                    RD,
   input  logic [DATA_WIDTH/8-1:0] BE,
   input  logic [DATA_WIDTH-1:0]   DI,
   output logic [DATA_WIDTH-1:0]   DO,
   output logic                    WRAck,
   output logic                    RDAck,
   output logic                    Busy
);

   localparam int BE_W = DATA_WIDTH/8;

   logic [1:0]            state, next_state;
   logic [CNT_W-1:0]      cnt;
   logic                  op_wr;
   logic [ADDR_BITS-1:0]  addr_q;
   logic [BE_W-1:0]       be_q;
   logic [DATA_WIDTH-1:0] di_q;
   logic                  do_valid;
   logic [DATA_WIDTH-1:0] rdata;

   logic                  sel, req, start, go_ack;
   logic                  c_wr;
   logic [ADDR_BITS-1:0]  c_addr;
   logic [BE_W-1:0]       c_be;
   logic [DATA_WIDTH-1:0] c_di;

   assign sel   = ((Addr & SEL_MASK) == SEL_BASE);
   assign req   = sel && (WE || RD);
   assign start = (state == ST_IDLE) && req;

   // Next state, and the operation being committed on the edge that enters ACK.
   // A latency-1 op commits straight from the live inputs; longer ones use the latched copy.
   always_comb begin
      next_state = state;
      go_ack     = 1'b0;
      c_wr       = op_wr;
      c_addr     = addr_q;
      c_be       = be_q;
      c_di       = di_q;
      case (state)
         ST_IDLE: begin
            if (req) begin
               c_wr   = WE;
               c_addr = Addr[ADDR_BITS-1:0];
               c_be   = BE;
               c_di   = DI;
               if ((WE ? WR_LATENCY : RD_LATENCY) == 1) begin
                  next_state = ST_ACK;
                  go_ack     = 1'b1;
               end else begin
                  next_state = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (cnt == CNT_W'(1)) begin
               next_state = ST_ACK;
               go_ack     = 1'b1;
            end
         end
         ST_ACK:  next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Control state: FSM, latency counter, acks, busy flag and read-data valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         op_wr    <= 1'b0;
         WRAck    <= 1'b0;
         RDAck    <= 1'b0;
         Busy     <= 1'b0;
         do_valid <= 1'b0;
      end else begin
         state <= next_state;
         if (start) begin
            op_wr <= WE;
            cnt   <= lat_preload(WE ? WR_LATENCY : RD_LATENCY);
         end else if (state == ST_BUSY) begin
            cnt <= cnt - CNT_W'(1);
         end
         WRAck    <= go_ack && c_wr;
         RDAck    <= go_ack && !c_wr;
         Busy     <= (next_state != ST_IDLE);
         do_valid <= do_valid || (go_ack && !c_wr);
      end
   end

   // Request capture; only meaningful while an op is outstanding, so left unreset
   always_ff @(posedge clk) begin
      if (start) begin
         addr_q <= Addr[ADDR_BITS-1:0];
         be_q   <= BE;
         di_q   <= DI;
      end
   end

   vproc_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (ADDR_BITS),
      .INIT_FILE  (INIT_FILE)
   ) u_array (
      .clk   (clk),
      .wr    (go_ack && c_wr && !reset),
      .rd    (go_ack && !c_wr && !reset),
      .addr  (c_addr),
      .be    (c_be),
      .wdata (c_di),
      .rdata (rdata)
   );

   // DO reads as zero until the first read completes after reset
   assign DO = do_valid ? rdata : '0;

endmodule

// File: tb/tb_vproc_mem.sv
// Directed bench for vproc_mem: three instances with different latencies
// share the address/data bus and have their own strobes and resets.
module tb_vproc_mem;

   logic        clk = 1'b0;
   logic [31:0] addr;
   logic [31:0] di;
   logic [3:0]  be;
   logic        we    [3];
   logic        rd    [3];
   logic        rst   [3];
   logic [31:0] dout  [3];
   logic        wrack [3];
   logic        rdack [3];
   logic        busy  [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vproc_mem u_dut0 (
      .clk(clk), .reset(rst[0]), .Addr(addr), .WE(we[0]), .RD(rd[0]), .BE(be), .DI(di),
      .DO(dout[0]), .WRAck(wrack[0]), .RDAck(rdack[0]), .Busy(busy[0]));

   vproc_mem #(.RD_LATENCY(4), .WR_LATENCY(2)) u_dut1 (
      .clk(clk), .reset(rst[1]), .Addr(addr), .WE(we[1]), .RD(rd[1]), .BE(be), .DI(di),
      .DO(dout[1]), .WRAck(wrack[1]), .RDAck(rdack[1]), .Busy(busy[1]));

   vproc_mem #(.RD_LATENCY(1), .WR_LATENCY(4)) u_dut2 (
      .clk(clk), .reset(rst[2]), .Addr(addr), .WE(we[2]), .RD(rd[2]), .BE(be), .DI(di),
      .DO(dout[2]), .WRAck(wrack[2]), .RDAck(rdack[2]), .Busy(busy[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Counts edges (from the first edge after the strobe) until the ack is seen; -1 on timeout
   task automatic wait_ack(input int d, input bit want_wr, output int lat, output int bcnt);
      bit seen = 1'b0;
      lat  = 0;
      bcnt = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         lat++;
         if (busy[d]) bcnt++;
         if (want_wr ? wrack[d] : rdack[d]) seen = 1'b1;
      end
      if (!seen) lat = -1;
   endtask

   task automatic write_op(input int d, input logic [31:0] a, input logic [31:0] data,
                           input logic [3:0] b, input int exp_lat, input string tag);
      int lat, bc;
      addr = a; di = data; be = b; we[d] = 1'b1;
      wait_ack(d, 1'b1, lat, bc);
      chk({tag, "_wlat"}, lat, exp_lat);
      chk({tag, "_wbusy"}, bc, exp_lat);
      we[d] = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_wack_drop"}, wrack[d], 1'b0);
   endtask

   task automatic read_op(input int d, input logic [31:0] a, input logic [31:0] exp_data,
                          input int exp_lat, input string tag);
      int lat, bc;
      addr = a; rd[d] = 1'b1;
      wait_ack(d, 1'b0, lat, bc);
      chk({tag, "_rlat"}, lat, exp_lat);
      chk({tag, "_rbusy"}, bc, exp_lat);
      chk({tag, "_rdata"}, dout[d], exp_data);
      rd[d] = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_rack_drop"}, rdack[d], 1'b0);
      chk({tag, "_do_hold"}, dout[d], exp_data);
   endtask

   initial begin
      int lat, bc, hits;
      addr = '0; di = '0; be = '0;
      for (int i = 0; i < 3; i++) begin
         we[i] = 1'b0; rd[i] = 1'b0; rst[i] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_do", dout[0], 32'h0);
      chk("rst_wrack", wrack[0], 1'b0);
      chk("rst_rdack", rdack[0], 1'b0);
      chk("rst_busy", busy[0], 1'b0);
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      @(posedge clk); #1;

      // Default latencies: write then read back
      write_op(0, 32'ha000_0004, 32'hdeadbeef, 4'hf, 1, "dflt");
      read_op(0, 32'ha000_0004, 32'hdeadbeef, 1, "dflt");

      // Byte enables
      write_op(0, 32'ha000_0008, 32'h11223344, 4'hf, 1, "be_init");
      write_op(0, 32'ha000_0008, 32'haabbccdd, 4'b0101, 1, "be_part");
      read_op(0, 32'ha000_0008, 32'h11bb33dd, 1, "be");

      // Unselected address: no ack, never busy, array untouched
      addr = 32'hb000_0004; di = 32'h0; be = 4'hf; we[0] = 1'b1;
      hits = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (wrack[0] || busy[0]) hits++;
      end
      chk("unsel_activity", hits, 0);
      we[0] = 1'b0;
      read_op(0, 32'ha000_0004, 32'hdeadbeef, 1, "unsel");

      // Simultaneous WE+RD: write served first, read in the following transaction
      addr = 32'ha000_0010; di = 32'h5; be = 4'hf; we[0] = 1'b1; rd[0] = 1'b1;
      wait_ack(0, 1'b1, lat, bc);
      chk("both_wlat", lat, 1);
      chk("both_no_rdack", rdack[0], 1'b0);
      we[0] = 1'b0;
      wait_ack(0, 1'b0, lat, bc);
      chk("both_rlat", lat, 2);
      chk("both_wack_low", wrack[0], 1'b0);
      chk("both_rdata", dout[0], 32'h5);
      rd[0] = 1'b0;
      @(posedge clk); #1;

      // Longer latencies
      write_op(1, 32'ha000_0020, 32'hcafe0001, 4'hf, 2, "lat");
      read_op(1, 32'ha000_0020, 32'hcafe0001, 4, "lat");

      // Reset during BUSY of a write aborts it
      write_op(2, 32'ha000_0008, 32'h0badf00d, 4'hf, 4, "rst_old");
      read_op(2, 32'ha000_0008, 32'h0badf00d, 1, "rst_old");
      addr = 32'ha000_0008; di = 32'h12345678; be = 4'hf; we[2] = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy_pre", busy[2], 1'b1);
      @(posedge clk); #1;
      rst[2] = 1'b1;
      #1;
      chk("abort_wrack", wrack[2], 1'b0);
      chk("abort_busy", busy[2], 1'b0);
      chk("abort_do", dout[2], 32'h0);
      we[2] = 1'b0;
      @(posedge clk); #1;
      rst[2] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_idle", busy[2], 1'b0);
      read_op(2, 32'ha000_0008, 32'h0badf00d, 1, "abort");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
